io_in_debounce: RTL and testbench
=================================

IO_IN_DEBOUNCE -- requirements
Module: io_in_debounce

Interface
REQ-001 SHALL provide parameter DB_CNT_W, default 8, giving the debounce counter and db_limit width in bits.
REQ-002 SHALL have port mclk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port puc_rst, input, 1, the reset; synchronous and active-high.
REQ-004 SHALL have port pad_din, input, 1, the raw pad level from the input buffer, asynchronous to mclk.
REQ-005 SHALL have port db_en, input, 1, where 1 enables debouncing and 0 makes dout follow the synchronized input.
REQ-006 SHALL have port db_limit, input, DB_CNT_W, the debounce length N in mclk cycles.
REQ-007 SHALL have port irq_edge_sel, input, 1, where 0 selects the rising edge and 1 the falling edge for irq_flag.
REQ-008 SHALL have port irq_clr, input, 1, a one-cycle clear of irq_flag.
REQ-009 SHALL have port dout, output, 1, the debounced level (registered).
REQ-010 SHALL have port rise_p, output, 1, a one-cycle pulse when dout goes 0->1.
REQ-011 SHALL have port fall_p, output, 1, a one-cycle pulse when dout goes 1->0.
REQ-012 SHALL have port irq_flag, output, 1, a sticky edge flag.
REQ-013 SHALL have port busy, output, 1, high while the FSM is in COUNT.

Function
REQ-014 SHALL pass pad_din through a 2-flop synchronizer; its output is sync_q.
REQ-015 SHALL implement FSM states IDLE and COUNT with counter cnt (DB_CNT_W bits).
REQ-016 In IDLE, with db_en=1 and sync_q!=dout: if db_limit=0, SHALL toggle dout on that edge; otherwise SHALL enter COUNT with cnt=1.
REQ-017 In COUNT, if sync_q==dout, SHALL return to IDLE with cnt=0 and dout unchanged (glitch rejected).
REQ-018 In COUNT, if sync_q!=dout and cnt>=db_limit, SHALL toggle dout, return to IDLE and clear cnt.
REQ-019 In COUNT otherwise, SHALL increment cnt; cnt never exceeds db_limit, so no wrap occurs, including when db_limit is all ones.
REQ-020 Latency SHALL be: a clean pad_din step first sampled at edge 1 appears on dout at edge N+3.
REQ-021 db_limit changed mid-COUNT SHALL take effect immediately; if the new value is <=cnt, dout toggles on the next edge.
REQ-022 With db_en=0, SHALL set dout to sync_q each edge, force IDLE and clear cnt; deasserting db_en mid-COUNT aborts the count.
REQ-023 rise_p/fall_p SHALL be registered, asserted for exactly the first cycle in which dout holds its new value, and never asserted together.
REQ-024 The selected edge pulse SHALL set irq_flag; irq_clr SHALL clear it; when set and clear coincide, set SHALL win.
REQ-025 busy SHALL be 1 exactly when the state is COUNT.

Reset
REQ-026 While puc_rst=1, SHALL hold both synchronizer flops, dout, cnt, rise_p, fall_p, irq_flag and busy at 0, with the state at IDLE.
REQ-027 Reset asserted mid-COUNT SHALL abort the count; after release, a pad held at 1 produces a rising transition per REQ-020.

Configuration
REQ-028 With macro IO_DEBOUNCE_SYNC3_EN defined, SHALL use a 3-flop synchronizer, and REQ-020 latency becomes N+4; without it, SHALL use 2 flops with latency N+3.

Verification
REQ-029 Scenario: db_en=1, db_limit=4, pad 0->1 clean -> dout=1 at edge 7, rise_p high one cycle, irq_flag=1 (irq_edge_sel=0).
REQ-030 Scenario: db_limit=4, pad high for 3 cycles then low -> dout stays 0, busy pulses, no rise_p.
REQ-031 Scenario: db_limit=0 and db_en=0, each with a pad step -> dout changes at edge 3 in both cases.
REQ-032 Scenario: db_limit=10, change to 2 when cnt=5 -> dout toggles on the next edge.
REQ-033 Scenario: irq_clr coincident with fall_p and irq_edge_sel=1 -> irq_flag stays 1; irq_clr alone next cycle -> irq_flag=0.
REQ-034 Scenario: puc_rst asserted with cnt=3 in COUNT -> all outputs 0 next edge; pad held at 1 gives dout=1 at edge N+3 after release.

Source files
------------

// File: rtl/io_in_debounce.sv
// Pad input conditioner: synchronizer, debounce FSM, edge pulses and a sticky edge flag.
// Define IO_DEBOUNCE_SYNC3_EN for a 3-flop synchronizer (one extra cycle of latency).
module io_in_debounce #(
    parameter int DB_CNT_W = 8
) (
    input  logic                mclk,
    input  logic                puc_rst,
    input  logic                pad_din,
    input  logic                db_en,
    input  logic [DB_CNT_W-1:0] db_limit,
    input  logic                irq_edge_sel,
    input  logic                irq_clr,
    output logic                dout,
    output logic                rise_p,
    output logic                fall_p,
    output logic                irq_flag,
    output logic                busy
);

`ifdef IO_DEBOUNCE_SYNC3_EN
    localparam int SYNC_N = 3;
`else
    localparam int SYNC_N = 2;
`endif

    localparam logic [DB_CNT_W-1:0] CNT_ZERO = {DB_CNT_W{1'b0}};
    localparam logic [DB_CNT_W-1:0] CNT_ONE  = {{(DB_CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_t;

    logic [SYNC_N-1:0]   sync_ff_q;
    logic                sync_q;
    state_t              state_q,  state_d;
    logic [DB_CNT_W-1:0] cnt_q,    cnt_d;
    logic                dout_q,   dout_d;
    logic                rise_q,   rise_d;
    logic                fall_q,   fall_d;
    logic                irq_q,    irq_d;
    logic                busy_q,   busy_d;

    assign sync_q = sync_ff_q[SYNC_N-1];

    // Metastability synchronizer for the asynchronous pad level.
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            sync_ff_q <= {SYNC_N{1'b0}};
        end else begin
            sync_ff_q <= {sync_ff_q[SYNC_N-2:0], pad_din};
        end
    end

    // Debounce FSM next state; cnt stops at db_limit so it can never wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        if (!db_en) begin
            dout_d  = sync_q;
            state_d = S_IDLE;
            cnt_d   = CNT_ZERO;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (sync_q != dout_q) begin
                        if (db_limit == CNT_ZERO) begin
                            dout_d = ~dout_q;
                        end else begin
                            state_d = S_COUNT;
                            cnt_d   = CNT_ONE;
                        end
                    end else begin
                        cnt_d = CNT_ZERO;
                    end
                end
                S_COUNT: begin
                    if (sync_q == dout_q) begin
                        state_d = S_IDLE;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q >= db_limit) begin
                        dout_d  = ~dout_q;
                        state_d = S_IDLE;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // Edge pulses track the dout transition; the flag is set from the pulse one cycle later.
    always_comb begin
        rise_d = dout_d & ~dout_q;
        fall_d = ~dout_d & dout_q;
        busy_d = (state_d == S_COUNT);
        if (irq_edge_sel ? fall_q : rise_q) begin
            irq_d = 1'b1;
        end else if (irq_clr) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    // State and output registers.
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_ZERO;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            irq_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            irq_q   <= irq_d;
            busy_q  <= busy_d;
        end
    end

    assign dout     = dout_q;
    assign rise_p   = rise_q;
    assign fall_p   = fall_q;
    assign irq_flag = irq_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_io_in_debounce.sv
// Directed bench for io_in_debounce: table of pad-step vectors plus hand-written corner sequences.
module tb_io_in_debounce;

`ifdef IO_DEBOUNCE_SYNC3_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic       mclk = 1'b0;
    logic       puc_rst = 1'b1;
    logic       pad_din = 1'b0;
    logic       db_en = 1'b1;
    logic [7:0] db_limit = 8'd4;
    logic       irq_edge_sel = 1'b0;
    logic       irq_clr = 1'b0;
    logic       dout, rise_p, fall_p, irq_flag, busy;

    int n_cmp = 0;
    int n_bad = 0;
    logic both_seen = 1'b0;

    io_in_debounce #(.DB_CNT_W(8)) dut (
        .mclk(mclk), .puc_rst(puc_rst), .pad_din(pad_din), .db_en(db_en),
        .db_limit(db_limit), .irq_edge_sel(irq_edge_sel), .irq_clr(irq_clr),
        .dout(dout), .rise_p(rise_p), .fall_p(fall_p), .irq_flag(irq_flag), .busy(busy)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        logic       en;
        logic [7:0] lim;
        int         len;       // cycles pad stays high, 0 = stays high
        int         exp_edge;  // first edge with dout=1, 0 = never
        int         exp_rise;  // cycles rise_p is high
        logic       exp_busy;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
        if (rise_p && fall_p) both_seen = 1'b1;
    endtask

    task automatic do_reset();
        puc_rst = 1'b1;
        pad_din = 1'b0;
        tick();
        tick();
        puc_rst = 1'b0;
    endtask

    initial begin
        int first;
        int rises;
        logic busy_seen;
        int exp_e;
        int waited;

        vecs[0] = '{1'b1, 8'd4,   0, 7,   1, 1'b1};
        vecs[1] = '{1'b1, 8'd4,   3, 0,   0, 1'b1};
        vecs[2] = '{1'b1, 8'd0,   0, 3,   1, 1'b0};
        vecs[3] = '{1'b0, 8'd4,   0, 3,   1, 1'b0};
        vecs[4] = '{1'b1, 8'd1,   0, 4,   1, 1'b1};
        vecs[5] = '{1'b1, 8'd255, 0, 258, 1, 1'b1};
        vecs[6] = '{1'b1, 8'd2,   3, 5,   1, 1'b1};
        vecs[7] = '{1'b1, 8'd2,   2, 0,   0, 1'b1};

        // Reset state
        do_reset();
        check("rst_dout", int'(dout), 0);
        check("rst_rise", int'(rise_p), 0);
        check("rst_fall", int'(fall_p), 0);
        check("rst_irq", int'(irq_flag), 0);
        check("rst_busy", int'(busy), 0);

        for (int v = 0; v < 8; v++) begin
            db_en = vecs[v].en;
            db_limit = vecs[v].lim;
            irq_edge_sel = 1'b0;
            do_reset();
            pad_din = 1'b1;
            first = 0;
            rises = 0;
            busy_seen = 1'b0;
            for (int e = 1; e <= 300; e++) begin
                tick();
                if (dout && first == 0) first = e;
                if (rise_p) rises++;
                if (busy) busy_seen = 1'b1;
                if (vecs[v].len != 0 && e == vecs[v].len) pad_din = 1'b0;
            end
            exp_e = (vecs[v].exp_edge == 0) ? 0 : vecs[v].exp_edge + EXTRA;
            check($sformatf("v%0d_edge", v), first, exp_e);
            check($sformatf("v%0d_rise", v), rises, vecs[v].exp_rise);
            check($sformatf("v%0d_busy", v), int'(busy_seen), int'(vecs[v].exp_busy));
            check($sformatf("v%0d_irq", v), int'(irq_flag), (vecs[v].exp_rise > 0) ? 1 : 0);
        end

        // db_limit lowered from 10 to 2 while cnt=5
        db_en = 1'b1;
        db_limit = 8'd10;
        irq_edge_sel = 1'b0;
        do_reset();
        pad_din = 1'b1;
        for (int e = 1; e <= 7 + EXTRA; e++) tick();
        check("lim_chg_pre_dout", int'(dout), 0);
        check("lim_chg_pre_busy", int'(busy), 1);
        db_limit = 8'd2;
        tick();
        check("lim_chg_dout", int'(dout), 1);
        check("lim_chg_rise", int'(rise_p), 1);
        check("lim_chg_busy", int'(busy), 0);

        // irq_clr coincident with a falling pulse: set wins
        irq_clr = 1'b1;
        tick();
        tick();
        check("irq_clr_only", int'(irq_flag), 0);
        irq_clr = 1'b0;
        irq_edge_sel = 1'b1;
        pad_din = 1'b0;
        waited = 0;
        while (!fall_p && waited < 30) begin
            tick();
            waited++;
        end
        check("fall_seen", int'(fall_p), 1);
        check("fall_dout", int'(dout), 0);
        irq_clr = 1'b1;
        tick();
        check("irq_set_wins", int'(irq_flag), 1);
        check("fall_one_cycle", int'(fall_p), 0);
        tick();
        check("irq_cleared", int'(irq_flag), 0);
        irq_clr = 1'b0;

        // Reset in the middle of a count, then recovery with pad held high
        db_limit = 8'd4;
        irq_edge_sel = 1'b0;
        pad_din = 1'b1;
        for (int e = 1; e <= 5 + EXTRA; e++) tick();
        check("midcnt_busy", int'(busy), 1);
        puc_rst = 1'b1;
        tick();
        check("midrst_dout", int'(dout), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_irq", int'(irq_flag), 0);
        check("midrst_pulses", int'(rise_p | fall_p), 0);
        tick();
        puc_rst = 1'b0;
        for (int e = 1; e <= 6 + EXTRA; e++) tick();
        check("rec_pre_dout", int'(dout), 0);
        tick();
        check("rec_dout", int'(dout), 1);
        check("rec_rise", int'(rise_p), 1);

        check("pulse_exclusive", int'(both_seen), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
